// File: rtl/mux_pkg.sv
// ---------------------------------------------------------------------------
// mux_pkg
// Shared definitions for the behavioural 4:1 multiplexer.
//   SEL_L0..SEL_L3 : select codes for lanes 0..3
//   N_LANES        : number of data lanes packed on the D bus
//   sel_t          : 2-bit lane select type
// ---------------------------------------------------------------------------
package mux_pkg;

    typedef logic [1:0] sel_t;

    localparam int   N_LANES = 4;

    localparam sel_t SEL_L0 = 2'b00;
    localparam sel_t SEL_L1 = 2'b01;
    localparam sel_t SEL_L2 = 2'b10;
    localparam sel_t SEL_L3 = 2'b11;

endpackage : mux_pkg

// File: rtl/mux4_lane.sv
// ---------------------------------------------------------------------------
// mux4_lane
// Combinational leaf: unpacks four WIDTH-bit lanes from a packed bus and
// selects one of them by a binary index.
//   d_i [N_LANES*WIDTH-1:0] : packed lanes, lane i at d_i[i*WIDTH +: WIDTH]
//   s_i [1:0]               : lane select
//   y_o [WIDTH-1:0]         : selected lane (all-zeros on a non-binary select)
// ---------------------------------------------------------------------------
module mux4_lane
    import mux_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic [N_LANES*WIDTH-1:0] d_i,
    input  sel_t                     s_i,
    output logic [WIDTH-1:0]         y_o
);

    logic [WIDTH-1:0] lane [N_LANES];

    for (genvar gi = 0; gi < N_LANES; gi++) begin : g_lane
        assign lane[gi] = d_i[gi*WIDTH +: WIDTH];
    end

    // The default arm is reached only when s_i carries X/Z; the output is
    // then forced to zeros so downstream logic never sees a guessed lane.
    always_comb begin
        y_o = '0;
        case (s_i)
            SEL_L0:  y_o = lane[0];
            SEL_L1:  y_o = lane[1];
            SEL_L2:  y_o = lane[2];
            SEL_L3:  y_o = lane[3];
            default: y_o = '0;
        endcase
    end

endmodule : mux4_lane

// File: rtl/mux_comportamental.sv
// ---------------------------------------------------------------------------
// mux_comportamental
// Behavioural 4:1 multiplexer with a zero-latency combinational output and a
// registered copy of the selection for timing-critical consumers.
//   clk   : system clock, registers update on the rising edge
//   rst_n : asynchronous active-low reset (clears Y_q and S_q)
//   D     : packed data lanes, lane i at D[i*WIDTH +: WIDTH], lane 0 in LSBs
//   S     : lane select 0..3
//   en    : capture enable for Y_q / S_q
//   Y     : combinational selected lane
//   Y_q   : registered selected lane (1 clock after D/S when en=1)
//   S_q   : registered select that produced Y_q
// ---------------------------------------------------------------------------
module mux_comportamental
    import mux_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_LANES*WIDTH-1:0] D,
    input  sel_t                     S,
    input  logic                     en,
    output logic [WIDTH-1:0]         Y,
    output logic [WIDTH-1:0]         Y_q,
    output sel_t                     S_q
);

    logic [WIDTH-1:0] y_comb;
    logic [WIDTH-1:0] y_q_q;
    logic [WIDTH-1:0] y_q_d;
    sel_t             s_q_q;
    sel_t             s_q_d;

    mux4_lane #(
        .WIDTH (WIDTH)
    ) u_lane (
        .d_i (D),
        .s_i (S),
        .y_o (y_comb)
    );

    // Y is independent of clock, reset and enable.
    assign Y = y_comb;

    // The register captures the combinational value present before the edge,
    // so Y_q and S_q always describe the same selection.
    always_comb begin
        y_q_d = y_q_q;
        s_q_d = s_q_q;
        if (en) begin
            y_q_d = y_comb;
            s_q_d = S;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q_q <= '0;
            s_q_q <= SEL_L0;
        end else begin
            y_q_q <= y_q_d;
            s_q_q <= s_q_d;
        end
    end

    assign Y_q = y_q_q;
    assign S_q = s_q_q;

endmodule : mux_comportamental

// File: tb/tb_mux_comportamental.sv
// ---------------------------------------------------------------------------
// tb_mux_comportamental
// Directed bench for mux_comportamental: a WIDTH=1 instance and a WIDTH=8
// instance share clock, reset and enable; each has its own D/S.
// ---------------------------------------------------------------------------
module tb_mux_comportamental;

    logic       clk;
    logic       rst_n;
    logic       en;

    logic [3:0]  d1;
    logic [1:0]  s1;
    logic [0:0]  y1, y_q1;
    logic [1:0]  s_q1;

    logic [31:0] d8;
    logic [1:0]  s8;
    logic [7:0]  y8, y_q8;
    logic [1:0]  s_q8;

    int n_cmp;
    int n_err;

    logic [7:0] exp_q[$];

    mux_comportamental #(.WIDTH(1)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .D     (d1),
        .S     (s1),
        .en    (en),
        .Y     (y1),
        .Y_q   (y_q1),
        .S_q   (s_q1)
    );

    mux_comportamental #(.WIDTH(8)) u_dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .D     (d8),
        .S     (s8),
        .en    (en),
        .Y     (y8),
        .Y_q   (y_q8),
        .S_q   (s_q8)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, got t=%0t required finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        en    = 1'b1;
        d1    = 4'b0011;
        s1    = 2'b00;
        d8    = {8'hDD, 8'hCC, 8'hBB, 8'hAA};
        s8    = 2'b00;
        @(posedge clk); #1;
        n_cmp++;
        if (y_q1 !== 1'b0) begin
            n_err++; $display("FAIL reset_yq1: got %b required 0", y_q1);
        end
        n_cmp++;
        if (y_q8 !== 8'h00) begin
            n_err++; $display("FAIL reset_yq8: got %h required 00", y_q8);
        end
        n_cmp++;
        if (s_q8 !== 2'b00) begin
            n_err++; $display("FAIL reset_sq8: got %b required 00", s_q8);
        end
        n_cmp++;
        if (y8 !== 8'hAA) begin
            n_err++; $display("FAIL reset_y8_comb: got %h required aa", y8);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_select_sweep_w1();
        logic [0:0] exp_y [4];
        exp_y[0] = 1'b1; exp_y[1] = 1'b1; exp_y[2] = 1'b0; exp_y[3] = 1'b0;
        en = 1'b1;
        d1 = 4'b0011;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            s1 = 2'(i);
            #1;
            n_cmp++;
            if (y1 !== exp_y[i]) begin
                n_err++; $display("FAIL w1_y s=%0d: got %b required %b", i, y1, exp_y[i]);
            end
            @(posedge clk); #1;
            n_cmp++;
            if (y_q1 !== exp_y[i] || s_q1 !== 2'(i)) begin
                n_err++;
                $display("FAIL w1_yq s=%0d: got y_q=%b s_q=%0d required y_q=%b s_q=%0d",
                         i, y_q1, s_q1, exp_y[i], i);
            end
            @(negedge clk);  // hold each select for 20 ns
        end
        $display("select sweep WIDTH=1 complete");
    endtask

    task automatic test_wide_lanes();
        logic [7:0] exp_y [4];
        exp_y[0] = 8'hAA; exp_y[1] = 8'hBB; exp_y[2] = 8'hCC; exp_y[3] = 8'hDD;
        en = 1'b1;
        d8 = {8'hDD, 8'hCC, 8'hBB, 8'hAA};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            s8 = 2'(i);
            #1;
            n_cmp++;
            if (y8 !== exp_y[i]) begin
                n_err++; $display("FAIL w8_y s=%0d: got %h required %h", i, y8, exp_y[i]);
            end
            @(posedge clk); #1;
            n_cmp++;
            if (y_q8 !== exp_y[i] || s_q8 !== 2'(i)) begin
                n_err++;
                $display("FAIL w8_yq s=%0d: got y_q=%h s_q=%0d required y_q=%h s_q=%0d",
                         i, y_q8, s_q8, exp_y[i], i);
            end
        end
    endtask

    task automatic test_enable_hold();
        logic [1:0] s_seq [5];
        s_seq[0] = 2'd0; s_seq[1] = 2'd3; s_seq[2] = 2'd1; s_seq[3] = 2'd0; s_seq[4] = 2'd3;
        @(negedge clk);
        en = 1'b1;
        d8 = {8'hDD, 8'hCC, 8'hBB, 8'hAA};
        s8 = 2'd2;
        @(posedge clk); #1;
        n_cmp++;
        if (y_q8 !== 8'hCC || s_q8 !== 2'd2) begin
            n_err++; $display("FAIL hold_load: got y_q=%h s_q=%0d required y_q=cc s_q=2", y_q8, s_q8);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            en = 1'b0;
            d8 = {8'h40 + 8'(i), 8'h30 + 8'(i), 8'h20 + 8'(i), 8'h10 + 8'(i)};
            s8 = s_seq[i];
            @(posedge clk); #1;
            n_cmp++;
            if (y_q8 !== 8'hCC || s_q8 !== 2'd2) begin
                n_err++;
                $display("FAIL hold_cycle%0d: got y_q=%h s_q=%0d required y_q=cc s_q=2", i, y_q8, s_q8);
            end
        end
        // last vector: D = {44,34,24,14}, S = 3 -> lane 3 = 44
        @(negedge clk);
        en = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (y_q8 !== 8'h44 || s_q8 !== 2'd3) begin
            n_err++; $display("FAIL hold_release: got y_q=%h s_q=%0d required y_q=44 s_q=3", y_q8, s_q8);
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] s_seq [6];
        logic [7:0] exp_y [4];
        logic [7:0] exp_v;
        s_seq[0] = 2'd3; s_seq[1] = 2'd0; s_seq[2] = 2'd2;
        s_seq[3] = 2'd2; s_seq[4] = 2'd1; s_seq[5] = 2'd0;
        exp_y[0] = 8'h5A; exp_y[1] = 8'hA5; exp_y[2] = 8'h0F; exp_y[3] = 8'hF0;
        @(negedge clk);
        en = 1'b1;
        d8 = {8'hF0, 8'h0F, 8'hA5, 8'h5A};
        for (int i = 0; i < 6; i++) begin
            s8 = s_seq[i];
            exp_q.push_back(exp_y[s_seq[i]]);
            @(posedge clk); #1;
            exp_v = exp_q.pop_front();
            n_cmp++;
            if (y_q8 !== exp_v) begin
                n_err++; $display("FAIL b2b_%0d: got %h required %h", i, y_q8, exp_v);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        en = 1'b1;
        d8 = {8'hDD, 8'hCC, 8'hBB, 8'hAA};
        s8 = 2'd3;
        @(posedge clk); #3;
        rst_n = 1'b0;  // mid-cycle, no clock edge
        #1;
        n_cmp++;
        if (y_q8 !== 8'h00 || s_q8 !== 2'b00) begin
            n_err++; $display("FAIL async_clear: got y_q=%h s_q=%b required y_q=00 s_q=00", y_q8, s_q8);
        end
        n_cmp++;
        if (y8 !== 8'hDD) begin
            n_err++; $display("FAIL async_y_comb: got %h required dd", y8);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (y_q8 !== 8'h00) begin
            n_err++; $display("FAIL async_hold: got %h required 00", y_q8);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (y_q8 !== 8'hDD || s_q8 !== 2'd3) begin
            n_err++; $display("FAIL async_release: got y_q=%h s_q=%0d required y_q=dd s_q=3", y_q8, s_q8);
        end
    endtask

    task automatic test_illegal_select();
        // Y_q holds a nonzero value first so the clear to zero is visible.
        // All lanes are zero during the X select, so the result does not
        // depend on how a two-state simulator resolves the X.
        @(negedge clk);
        en = 1'b1;
        d8 = {8'hDD, 8'hCC, 8'hBB, 8'hAA};
        s8 = 2'd1;
        @(posedge clk); #1;
        n_cmp++;
        if (y_q8 !== 8'hBB) begin
            n_err++; $display("FAIL illegal_preload: got %h required bb", y_q8);
        end
        @(negedge clk);
        d8 = 32'h0;
        s8 = 2'bxx;
        #1;
        n_cmp++;
        if (y8 !== 8'h00) begin
            n_err++; $display("FAIL illegal_y: got %h required 00", y8);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (y_q8 !== 8'h00) begin
            n_err++; $display("FAIL illegal_yq: got %h required 00", y_q8);
        end
        @(negedge clk);
        s8 = 2'd0;
    endtask

    // ---------------- sequence / report ----------------
    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_select_sweep_w1();
        test_wide_lanes();
        test_enable_hold();
        test_back_to_back();
        test_async_reset();
        test_illegal_select();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_mux_comportamental

// File: doc/mux_comportamental.md
Name: mux_comportamental

Overview:
- Behavioural 4:1 multiplexer. Selects one of four data lanes from a packed input bus using a 2-bit select.
- Drives the selection combinationally on Y for zero-latency use.
- Also provides a registered copy of the selection (Y_q, S_q) for timing-critical consumers.
- Leaf utility block used wherever a small select-by-index is needed in the datapath.

Parameters:
- WIDTH, 1, bit width of each data lane and of Y/Y_q (must be >= 1).

Ports:
- clk  input  1  system clock; all registers update on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- D  input  4*WIDTH  packed data lanes: lane i occupies D[i*WIDTH +: WIDTH], lane 0 in the LSBs.
- S  input  2  lane select; binary index 0..3.
- en  input  1  capture enable for the registered outputs.
- Y  output  WIDTH  combinational selected lane.
- Y_q  output  WIDTH  registered selected lane.
- S_q  output  2  registered select that produced Y_q.
- Port order in the declaration is exactly as listed above.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (clk, rst_n).
- Combinational path:
  - Y = lane S of D: S=00 gives D[WIDTH-1:0], 01 the next lane, 10 the third, 11 the top lane.
  - Pure combinational, zero latency; Y follows any change on D or S in the same delta.
  - Y is independent of clk, rst_n and en.
  - S containing X/Z (non-binary): Y drives all-zeros via the default branch. This is a decided behaviour, not left to synthesis.
- Registered path:
  - On rst_n low, immediately and regardless of clk: Y_q = 0 and S_q = 2'b00.
  - Reset release is synchronised by the normal flop behaviour; there is no extra reset synchroniser inside this block.
  - On a rising clk edge with rst_n high and en=1: Y_q <= value of Y before the edge, and S_q <= S.
  - With en=0: Y_q and S_q hold their values.
  - Latency from D/S to Y_q: exactly 1 clock when en=1.
  - Reset asserted mid-operation clears Y_q/S_q at once. Y keeps tracking D/S throughout reset.
- No handshake, no state machine, no arithmetic.
- Simultaneous change of S and D just before a clock edge: Y_q captures the post-change combinational value, subject to normal setup timing.

Decomposition:
- Shared package mux_pkg holds:
  - localparams SEL_L0=2'b00, SEL_L1=2'b01, SEL_L2=2'b10, SEL_L3=2'b11;
  - localparam N_LANES=4;
  - typedef sel_t as a 2-bit logic vector.
- Sub-module: none required. An optional mux4_lane combinational leaf (lane extraction plus case) is acceptable; mux_comportamental then wraps it with the output registers.

Test Plan:
- Select sweep, WIDTH=1, D=4'b0011, S = 00, 01, 10, 11, each held 20 ns -> Y = 1, 1, 0, 0 respectively. Bench prints a completion message at the end.
- Wide lanes, WIDTH=8, D={8'hDD,8'hCC,8'hBB,8'hAA}, S sweep 0..3 -> Y = AA, BB, CC, DD; Y_q matches Y one cycle later with en=1, and S_q tracks S.
- Enable hold: en=0 while S/D change over 5 cycles -> Y_q/S_q unchanged; en=1 -> they update on the next edge.
- Async reset: assert rst_n=0 mid-cycle (no clk edge) with Y_q nonzero -> Y_q=0 and S_q=00 immediately. Y still equals the selected lane during reset.
- Illegal select: S=2'bx -> Y=0; after an edge with en=1, Y_q=0.
